// File: rtl/forwarding_unit_pkg.sv
// forwarding_unit_pkg: shared forwarding select codes, register width, shadow record and FSM states
package forwarding_unit_pkg;
  localparam int REG_ADDR = 5;
  localparam int CORTOCIRCUITO = 3;
  localparam logic [CORTOCIRCUITO-1:0] FWD_REG = 3'b000;
  localparam logic [CORTOCIRCUITO-1:0] FWD_EXMEM = 3'b001;
  localparam logic [CORTOCIRCUITO-1:0] FWD_MEMWB = 3'b010;
  typedef enum logic {IDLE, STALL} state_t;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR-1:0] dst;
  } shadow_t;
endpackage

// File: rtl/forwarding_unit_if.sv
// forwarding_unit_if: pipeline-side bus of the forwarding unit; master = pipeline, slave = forwarding_unit; FORWARDING_STATS_EN adds fwd_count/stall_count
interface forwarding_unit_if;
  import forwarding_unit_pkg::*;
  logic enable;
  logic [REG_ADDR-1:0] ex_rs;
  logic [REG_ADDR-1:0] ex_rt;
  logic [REG_ADDR-1:0] ex_dst;
  logic ex_reg_write;
  logic ex_mem_read;
  logic [REG_ADDR-1:0] id_rs;
  logic [REG_ADDR-1:0] id_rt;
  logic id_uses_rt;
  logic [CORTOCIRCUITO-1:0] fwd_a;
  logic [CORTOCIRCUITO-1:0] fwd_b;
  logic stall;
  logic flush_idex;
`ifdef FORWARDING_STATS_EN
  logic [31:0] fwd_count;
  logic [31:0] stall_count;
  modport master (output enable, ex_rs, ex_rt, ex_dst, ex_reg_write, ex_mem_read, id_rs, id_rt, id_uses_rt,
                  input fwd_a, fwd_b, stall, flush_idex, fwd_count, stall_count);
  modport slave (input enable, ex_rs, ex_rt, ex_dst, ex_reg_write, ex_mem_read, id_rs, id_rt, id_uses_rt,
                 output fwd_a, fwd_b, stall, flush_idex, fwd_count, stall_count);
`else
  modport master (output enable, ex_rs, ex_rt, ex_dst, ex_reg_write, ex_mem_read, id_rs, id_rt, id_uses_rt,
                  input fwd_a, fwd_b, stall, flush_idex);
  modport slave (input enable, ex_rs, ex_rt, ex_dst, ex_reg_write, ex_mem_read, id_rs, id_rt, id_uses_rt,
                 output fwd_a, fwd_b, stall, flush_idex);
`endif
endinterface

// File: rtl/forwarding_unit_fwd_select.sv
// fwd_select: one operand's forwarding select; src in, exmem/memwb shadows in, sel out (EX/MEM wins, $0 never forwarded)
module fwd_select
  import forwarding_unit_pkg::*;
(
  input  logic [REG_ADDR-1:0] src,
  input  shadow_t exmem,
  input  shadow_t memwb,
  output logic [CORTOCIRCUITO-1:0] sel
);
  always_comb begin
    sel = (src == '0) ? FWD_REG :
          (exmem.valid && exmem.dst == src) ? FWD_EXMEM :
          (memwb.valid && memwb.dst == src) ? FWD_MEMWB : FWD_REG;
  end
endmodule

// File: rtl/forwarding_unit.sv
// forwarding_unit: EX forwarding selects and load-use stall FSM; ports clk, rst (async active-high), bus (forwarding_unit_if.slave); FORWARDING_STATS_EN adds counters
module forwarding_unit
  import forwarding_unit_pkg::*;
(
  input logic clk,
  input logic rst,
  forwarding_unit_if.slave bus
);
  shadow_t exmem, memwb;
  state_t state, state_nx;
  logic hazard, stall;
  logic [CORTOCIRCUITO-1:0] fwd_a, fwd_b;
  fwd_select u_a (.src(bus.ex_rs), .exmem(exmem), .memwb(memwb), .sel(fwd_a));
  fwd_select u_b (.src(bus.ex_rt), .exmem(exmem), .memwb(memwb), .sel(fwd_b));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem <= '0;
      memwb <= '0;
      state <= IDLE;
    end else if (bus.enable) begin
      exmem <= '{valid: bus.ex_reg_write, dst: bus.ex_dst};
      memwb <= exmem;
      state <= state_nx;
    end
  end
  always_comb begin
    hazard = bus.ex_mem_read && bus.ex_reg_write && bus.ex_dst != '0 &&
             (bus.ex_dst == bus.id_rs || (bus.id_uses_rt && bus.ex_dst == bus.id_rt));
    stall = (state == IDLE) && hazard;
    state_nx = (state == IDLE) ? (hazard ? STALL : IDLE) : IDLE;
  end
  assign bus.fwd_a = fwd_a;
  assign bus.fwd_b = fwd_b;
  assign bus.stall = stall;
  assign bus.flush_idex = stall;
`ifdef FORWARDING_STATS_EN
  logic [31:0] fwd_count, stall_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_count <= '0;
      stall_count <= '0;
    end else if (bus.enable) begin
      if ((fwd_a != FWD_REG || fwd_b != FWD_REG) && fwd_count != '1) fwd_count <= fwd_count + 32'd1;
      if (stall && stall_count != '1) stall_count <= stall_count + 32'd1;
    end
  end
  assign bus.fwd_count = fwd_count;
  assign bus.stall_count = stall_count;
`endif
endmodule

// File: tb/tb_forwarding_unit.sv
// tb_forwarding_unit: directed vector table, hand sequences and randomized reference-model checks for forwarding_unit
module tb_forwarding_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  forwarding_unit_if bus();
  forwarding_unit dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic [4:0] rs, rt, dst;
    logic rw, mr;
    logic [4:0] id_rs, id_rt;
    logic uses;
    logic [2:0] ea, eb;
    logic es;
  } vec_t;

  typedef struct {
    logic v;
    logic [4:0] d;
  } w_t;

  vec_t v[14];
  w_t hq[$];
  logic bub;
  int m_fwd, m_stall;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    @(negedge clk);
    bus.enable = x.en;
    bus.ex_rs = x.rs;
    bus.ex_rt = x.rt;
    bus.ex_dst = x.dst;
    bus.ex_reg_write = x.rw;
    bus.ex_mem_read = x.mr;
    bus.id_rs = x.id_rs;
    bus.id_rt = x.id_rt;
    bus.id_uses_rt = x.uses;
    #2;
  endtask

  task automatic check_out(input string n, input vec_t x);
    chk({n, ".fwd_a"}, 32'(bus.fwd_a), 32'(x.ea));
    chk({n, ".fwd_b"}, 32'(bus.fwd_b), 32'(x.eb));
    chk({n, ".stall"}, 32'(bus.stall), 32'(x.es));
    chk({n, ".flush"}, 32'(bus.flush_idex), 32'(x.es));
  endtask

  function automatic logic [2:0] msel(input logic [4:0] x);
    if (x == 0) return 3'd0;
    for (int i = 0; i < hq.size(); i++)
      if (hq[i].v && hq[i].d == x) return (i == 0) ? 3'd1 : 3'd2;
    return 3'd0;
  endfunction

  initial begin
    vec_t x, z;
    z = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 3'd0, 3'd0, 1'b0};
    bus.enable = 0; bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_dst = 0; bus.ex_reg_write = 0;
    bus.ex_mem_read = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
    #12;
    check_out("reset", z);
`ifdef FORWARDING_STATS_EN
    chk("reset.fwd_count", bus.fwd_count, 0);
    chk("reset.stall_count", bus.stall_count, 0);
`endif
    @(negedge clk) rst = 1'b0;
    //       en rs rt dst rw mr idrs idrt uses ea eb es
    v[0]  = '{1, 1, 2, 3, 1, 0, 3, 5, 1, 0, 0, 0};
    v[1]  = '{1, 3, 5, 4, 1, 0, 0, 0, 0, 1, 0, 0};
    v[2]  = '{1, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0};
    v[3]  = '{1, 0, 0, 0, 0, 0, 7, 3, 1, 0, 0, 0};
    v[4]  = '{1, 7, 3, 6, 1, 0, 0, 0, 0, 0, 2, 0};
    v[5]  = '{1, 6, 6, 3, 1, 0, 0, 0, 0, 1, 1, 0};
    v[6]  = '{1, 3, 3, 3, 1, 0, 0, 0, 0, 1, 1, 0};
    v[7]  = '{1, 3, 0, 10, 1, 0, 0, 0, 0, 1, 0, 0};
    v[8]  = '{1, 0, 8, 8, 1, 1, 8, 8, 1, 0, 0, 1};
    v[9]  = '{1, 0, 0, 0, 0, 0, 8, 8, 1, 0, 0, 0};
    v[10] = '{1, 8, 8, 9, 1, 0, 0, 0, 0, 2, 2, 0};
    v[11] = '{1, 1, 2, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    v[12] = '{1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    v[13] = '{1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      drive(v[i]);
      check_out($sformatf("vec%0d", i), v[i]);
    end
    x = '{0, 5, 0, 8, 1, 1, 8, 0, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) begin
      drive(x);
      check_out($sformatf("hold%0d", i), x);
    end
    x.en = 1;
    drive(x);
    check_out("hold_release", x);
    x.ea = 2; x.es = 0;
    drive(x);
    check_out("hold_bubble", x);
    x = '{1, 8, 0, 9, 1, 1, 9, 0, 0, 1, 0, 1};
    drive(x);
    check_out("pre_reset_load", x);
    x = '{1, 9, 0, 0, 0, 0, 9, 0, 0, 1, 0, 0};
    drive(x);
    check_out("pre_reset_stall", x);
    #1 rst = 1'b1;
    #1;
    check_out("async_reset", '{1, 9, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0});
`ifdef FORWARDING_STATS_EN
    chk("async_reset.fwd_count", bus.fwd_count, 0);
    chk("async_reset.stall_count", bus.stall_count, 0);
`endif
    drive(z);
    rst = 1'b0;
    hq.delete();
    bub = 0; m_fwd = 0; m_stall = 0;
    for (int c = 0; c < 2000; c++) begin
      logic h;
      x.en = ($urandom_range(0, 4) != 0);
      x.rs = 5'($urandom_range(0, 3));
      x.rt = 5'($urandom_range(0, 3));
      x.dst = 5'($urandom_range(0, 3));
      x.rw = ($urandom_range(0, 3) != 0);
      x.mr = ($urandom_range(0, 2) == 0);
      x.id_rs = 5'($urandom_range(0, 3));
      x.id_rt = 5'($urandom_range(0, 3));
      x.uses = 1'($urandom_range(0, 1));
      x.ea = msel(x.rs);
      x.eb = msel(x.rt);
      h = x.mr && x.rw && x.dst != 0 && (x.dst == x.id_rs || (x.uses && x.dst == x.id_rt));
      x.es = h && !bub;
      drive(x);
      check_out($sformatf("rnd%0d", c), x);
`ifdef FORWARDING_STATS_EN
      chk("rnd.fwd_count", bus.fwd_count, m_fwd);
      chk("rnd.stall_count", bus.stall_count, m_stall);
`endif
      if (x.en) begin
        hq.push_front('{x.rw, x.dst});
        if (hq.size() > 2) void'(hq.pop_back());
        bub = x.es;
        if (x.ea != 0 || x.eb != 0) m_fwd++;
        if (x.es) m_stall++;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
